// File: rtl/icache_dm_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Holds the FSM state encoding, the default geometry and the boolean constants.
package icache_dm_pkg;

    localparam int IC_INDEX_BITS = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_MISS = 2'd1,
        IC_FILL = 2'd2
    } ic_state_e;

endpackage

// File: rtl/icache_dm_array.sv
// One-word-per-line storage: combinational tag-compare read, single sync write port.
// Only the valid bits are reset, so tag/data can map onto plain RAM.
module icache_array #(
    parameter int INDEX_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [INDEX_BITS-1:0]    wr_index_i,
    input  logic [29-INDEX_BITS:0]   wr_tag_i,
    input  logic [31:0]              wr_data_i,
    input  logic [INDEX_BITS-1:0]    rd_index_i,
    input  logic [29-INDEX_BITS:0]   rd_tag_i,
    output logic                     hit_o,
    output logic [31:0]              word_o
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign hit_o  = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign word_o = data_q[rd_index_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped I-cache: 1-cycle hit, single-word refill from the memory controller on miss.
// busy holds fetch off during MISS/FILL; rdy low freezes every register.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int INDEX_BITS = IC_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_done
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    ic_state_e   state_q, state_d;
    logic        squash_q, squash_d;
    logic        ins_valid_q, ins_valid_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ins_pc_q, ins_pc_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic        arr_we;
    logic        arr_hit;
    logic [31:0] arr_word;

    icache_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .we_i       (arr_we),
        .wr_index_i (mem_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (mem_addr_q[31:INDEX_BITS+2]),
        .wr_data_i  (mem_data),
        .rd_index_i (fetch_pc[INDEX_BITS+1:2]),
        .rd_tag_i   (fetch_pc[31:INDEX_BITS+2]),
        .hit_o      (arr_hit),
        .word_o     (arr_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IC_IDLE;
            squash_q    <= FALSE;
            ins_valid_q <= FALSE;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            busy_q      <= FALSE;
            mem_req_q   <= FALSE;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            ins_valid_q <= ins_valid_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        ins_valid_d = ins_valid_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        arr_we      = FALSE;

        if (rdy) begin
            ins_valid_d = FALSE;
            case (state_q)
                IC_IDLE: begin
                    squash_d = FALSE;
                    if (fetch_valid && !clear) begin
                        if (arr_hit) begin
                            ins_valid_d = TRUE;
                            ins_d       = arr_word;
                            ins_pc_d    = fetch_pc;
                        end else begin
                            mem_addr_d = fetch_pc;
                            mem_req_d  = TRUE;
                            busy_d     = TRUE;
                            state_d    = IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    // Controller cannot abort mid-word: remember the redirect and finish the fill.
                    if (clear) begin
                        squash_d = TRUE;
                    end
                    if (mem_done) begin
                        arr_we    = TRUE;
                        mem_req_d = FALSE;
                        state_d   = IC_FILL;
                        if (!squash_q && !clear) begin
                            ins_valid_d = TRUE;
                            ins_d       = mem_data;
                            ins_pc_d    = mem_addr_q;
                        end
                    end
                end
                IC_FILL: begin
                    busy_d   = FALSE;
                    squash_d = FALSE;
                    state_d  = IC_IDLE;
                end
                default: begin
                    state_d = IC_IDLE;
                end
            endcase
        end
    end

    assign ins_valid = ins_valid_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: misses, hits, conflicts, redirects, stalls and reset.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_done;

    int total = 0;
    int bad   = 0;

    icache_dm dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_pc      (ins_pc),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_done    (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full miss sequence: request, one wait cycle, done pulse, FILL, back to IDLE.
    task automatic miss_fill(input string tag, input logic [31:0] pc, input logic [31:0] word);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        fetch_valid = 1'b0;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, pc);
        chk({tag, "_nohit"}, {31'd0, ins_valid}, 32'd0);
        tick();
        chk({tag, "_req_hold"}, {31'd0, mem_req}, 32'd1);
        mem_data = word;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        mem_data = 32'h0;
        chk({tag, "_vld"}, {31'd0, ins_valid}, 32'd1);
        chk({tag, "_ins"}, ins, word);
        chk({tag, "_pc"}, ins_pc, pc);
        chk({tag, "_fill_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_fill_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_vld"}, {31'd0, ins_valid}, 32'd0);
    endtask

    task automatic hit(input string tag, input logic [31:0] pc, input logic [31:0] word);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        chk({tag, "_vld"}, {31'd0, ins_valid}, 32'd1);
        chk({tag, "_ins"}, ins, word);
        chk({tag, "_pc"}, ins_pc, pc);
        chk({tag, "_noreq"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        fetch_valid = 1'b0; fetch_pc = 32'h0;
        mem_data = 32'h0; mem_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_vld", {31'd0, ins_valid}, 32'd0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_pc", ins_pc, 32'h0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // 1: cold miss
        miss_fill("cold10", 32'h0000_0010, 32'h00A0_0093);

        // 2: hit then streamed hits
        hit("rehit10", 32'h10, 32'h00A0_0093);
        fetch_valid = 1'b0;
        tick();
        miss_fill("fill14", 32'h14, 32'h0010_0113);
        miss_fill("fill18", 32'h18, 32'h0020_0193);
        hit("str10", 32'h10, 32'h00A0_0093);
        hit("str14", 32'h14, 32'h0010_0113);
        hit("str18", 32'h18, 32'h0020_0193);
        fetch_valid = 1'b0;
        tick();
        chk("str_end_vld", {31'd0, ins_valid}, 32'd0);

        // clear in IDLE drops a hit
        fetch_valid = 1'b1; fetch_pc = 32'h10; clear = 1'b1;
        tick();
        fetch_valid = 1'b0; clear = 1'b0;
        chk("idle_clr_vld", {31'd0, ins_valid}, 32'd0);
        chk("idle_clr_req", {31'd0, mem_req}, 32'd0);

        // 3: conflict on index 4
        miss_fill("conf410", 32'h410, 32'hDEAD_BEEF);
        miss_fill("conf10", 32'h10, 32'h00A0_0093);

        // 4: clear two cycles into a miss
        fetch_valid = 1'b1; fetch_pc = 32'h20;
        tick();
        fetch_valid = 1'b0;
        chk("sq_req0", {31'd0, mem_req}, 32'd1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("sq_req1", {31'd0, mem_req}, 32'd1);
        chk("sq_addr", mem_addr, 32'h20);
        tick();
        chk("sq_req2", {31'd0, mem_req}, 32'd1);
        mem_data = 32'h1234_5678; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("sq_vld", {31'd0, ins_valid}, 32'd0);
        chk("sq_fill_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("sq_idle_vld", {31'd0, ins_valid}, 32'd0);
        hit("sq_hit20", 32'h20, 32'h1234_5678);
        fetch_valid = 1'b0;
        tick();

        // clear coincident with mem_done
        fetch_valid = 1'b1; fetch_pc = 32'h50;
        tick();
        fetch_valid = 1'b0;
        tick();
        mem_data = 32'h5555_AAAA; mem_done = 1'b1; clear = 1'b1;
        tick();
        mem_done = 1'b0; clear = 1'b0;
        chk("cd_vld", {31'd0, ins_valid}, 32'd0);
        tick();
        hit("cd_hit50", 32'h50, 32'h5555_AAAA);
        fetch_valid = 1'b0;
        tick();

        // 5: rdy low mid-miss, including an ignored done pulse
        fetch_valid = 1'b1; fetch_pc = 32'h30;
        tick();
        fetch_valid = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_done = (i == 2);
            mem_data = 32'hBAD0_0000;
            tick();
            chk("stall_addr", mem_addr, 32'h30);
            chk("stall_req", {31'd0, mem_req}, 32'd1);
            chk("stall_vld", {31'd0, ins_valid}, 32'd0);
        end
        mem_done = 1'b0;
        rdy = 1'b1;
        tick();
        chk("stall_resume_req", {31'd0, mem_req}, 32'd1);
        mem_data = 32'hCAFE_F00D; mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("stall_vld_out", {31'd0, ins_valid}, 32'd1);
        chk("stall_ins", ins, 32'hCAFE_F00D);
        chk("stall_pc", ins_pc, 32'h30);
        tick();

        // 6: reset during MISS
        fetch_valid = 1'b1; fetch_pc = 32'h40;
        tick();
        fetch_valid = 1'b0;
        chk("rm_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_req0", {31'd0, mem_req}, 32'd0);
        chk("rm_busy0", {31'd0, busy}, 32'd0);
        chk("rm_vld0", {31'd0, ins_valid}, 32'd0);
        miss_fill("rm_miss10", 32'h10, 32'h00A0_0093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
